// File: rtl/pi_loop_sequencer_if.sv
// Handshake and status bundle between the PI loop sequencer and its environment.
// Latency: none, wires only.
// Backpressure: adc_valid / dac_ready stall the sequencer in SAMPLE / OUTPUT.
interface pi_loop_sequencer_if;
    logic       enable;
    logic       adc_valid;
    logic       dac_ready;
    logic       status_clr;
    logic [3:0] state;
    logic       adc_req;
    logic       dac_valid;
    logic       u_prev_load;
    logic       cycle_done;
    logic       overrun;
    logic       fault;

    modport master (
        input  enable, adc_valid, dac_ready, status_clr,
        output state, adc_req, dac_valid, u_prev_load, cycle_done, overrun, fault
    );

    modport slave (
        output enable, adc_valid, dac_ready, status_clr,
        input  state, adc_req, dac_valid, u_prev_load, cycle_done, overrun, fault
    );
endinterface

// File: rtl/pi_loop_sequencer.sv
// Master sequencer for the PI loop: paces iterations, broadcasts the state code, strobes u_prev reload.
// Latency: 4+ERR_CYCLES clocks per iteration with zero-wait handshakes; all outputs registered.
// Backpressure: waits in SAMPLE/OUTPUT for adc_valid/dac_ready; PI_SEQ_TIMEOUT_EN adds a timeout into FAULT.
module pi_loop_sequencer #(
    parameter logic [15:0] SAMPLE_DIV     = 16'd1000,
    parameter logic [3:0]  ERR_CYCLES     = 4'd1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
    input logic               clk,
    input logic               reset,
    pi_loop_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SAMPLE    = 4'd1,
        ST_COMPUTE_E = 4'd2,
        ST_COMPUTE_U = 4'd3,
        ST_OUTPUT    = 4'd4,
        ST_UPDATE    = 4'd5,
        ST_FAULT     = 4'd15
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] div_cnt;
    logic        tick;
    logic [3:0]  err_cnt;
    logic        adc_req_q;
    logic        dac_valid_q;
    logic        u_prev_load_q;
    logic        cycle_done_q;
    logic        overrun_q;

`ifdef PI_SEQ_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        fault_q;
    logic        wait_expired;

    assign wait_expired = (wait_cnt == TIMEOUT_CYCLES - 16'd1);
`else
    // Timeout limit has no meaning without the wait counter.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Sample tick only exists while the loop is enabled.
    assign tick = bus.enable && (div_cnt == SAMPLE_DIV - 16'd1);

    // Sample-rate divider: held at zero while disabled so the first tick lands SAMPLE_DIV clocks after enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= 16'd0;
        end else if (!bus.enable || tick) begin
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Next-state decision; unused codes fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.adc_valid) state_d = ST_COMPUTE_E;
`ifdef PI_SEQ_TIMEOUT_EN
                else if (wait_expired) state_d = ST_FAULT;
`endif
            end
            ST_COMPUTE_E: begin
                if (err_cnt == ERR_CYCLES - 4'd1) state_d = ST_COMPUTE_U;
            end
            ST_COMPUTE_U: begin
                state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.dac_ready) state_d = ST_UPDATE;
`ifdef PI_SEQ_TIMEOUT_EN
                else if (wait_expired) state_d = ST_FAULT;
`endif
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
`ifdef PI_SEQ_TIMEOUT_EN
            ST_FAULT: begin
                if (bus.status_clr) state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state, so they always match the state code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            adc_req_q     <= 1'b0;
            dac_valid_q   <= 1'b0;
            u_prev_load_q <= 1'b0;
            cycle_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            adc_req_q     <= (state_d == ST_SAMPLE);
            dac_valid_q   <= (state_d == ST_OUTPUT);
            u_prev_load_q <= (state_d == ST_UPDATE);
            cycle_done_q  <= (state_d == ST_UPDATE);
        end
    end

    // COMPUTE_E dwell counter: restarts whenever the state is not staying in COMPUTE_E.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 4'd0;
        end else if (state_q == ST_COMPUTE_E && state_d == ST_COMPUTE_E) begin
            err_cnt <= err_cnt + 4'd1;
        end else begin
            err_cnt <= 4'd0;
        end
    end

    // Sticky overrun: a tick outside IDLE is dropped and flagged; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (tick && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
        end else if (bus.status_clr) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef PI_SEQ_TIMEOUT_EN
    // Handshake wait counter: cleared on any state change, counts cycles the handshake stays unmet.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 16'd0;
        end else if (state_d != state_q) begin
            wait_cnt <= 16'd0;
        end else if ((state_q == ST_SAMPLE && !bus.adc_valid) ||
                     (state_q == ST_OUTPUT && !bus.dac_ready)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Fault flag mirrors residency in FAULT; it drops on the exit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.state       = state_q;
    assign bus.adc_req     = adc_req_q;
    assign bus.dac_valid   = dac_valid_q;
    assign bus.u_prev_load = u_prev_load_q;
    assign bus.cycle_done  = cycle_done_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Bench for pi_loop_sequencer: per-cycle vector table through a scoreboard queue, plus corner sequences.
// Two instances: ERR_CYCLES=1 for the main flow, ERR_CYCLES=4 for the wide compute window.
// Timeout sequence compiles in only with PI_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_pi_loop_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pi_loop_sequencer_if ifa();
    pi_loop_sequencer_if ifb();

    pi_loop_sequencer #(
        .SAMPLE_DIV(16'd10), .ERR_CYCLES(4'd1), .TIMEOUT_CYCLES(16'd16)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master)
    );

    pi_loop_sequencer #(
        .SAMPLE_DIV(16'd10), .ERR_CYCLES(4'd4), .TIMEOUT_CYCLES(16'd16)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master)
    );

    typedef struct {
        logic       en;
        logic       av;
        logic       dr;
        logic       clr;
        logic [3:0] st;
        logic       ov;
    } vec_t;

    localparam int NROWS = 115;

    vec_t vecs[NROWS+1];
    vec_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_st(input int a, input int b, input logic [3:0] s);
        for (int i = a; i <= b; i++) vecs[i].st = s;
    endtask

    // Compare every output of instance A against the expected state code and flags.
    task automatic check_a(input string tag, input vec_t e);
        chk({tag, " state"},       int'(ifa.state),       int'(e.st));
        chk({tag, " adc_req"},     int'(ifa.adc_req),     int'(e.st == 4'd1));
        chk({tag, " dac_valid"},   int'(ifa.dac_valid),   int'(e.st == 4'd4));
        chk({tag, " u_prev_load"}, int'(ifa.u_prev_load), int'(e.st == 4'd5));
        chk({tag, " cycle_done"},  int'(ifa.cycle_done),  int'(e.st == 4'd5));
        chk({tag, " overrun"},     int'(ifa.overrun),     int'(e.ov));
        chk({tag, " fault"},       int'(ifa.fault),       0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   n;

        // Row i holds inputs applied before the i-th edge after reset release and the state after it.
        for (int i = 0; i <= NROWS; i++) vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        set_st(10, 12, 4'd1); set_st(13, 13, 4'd2); set_st(14, 14, 4'd3);
        set_st(15, 15, 4'd4); set_st(16, 16, 4'd5);
        set_st(20, 20, 4'd1); set_st(21, 21, 4'd2); set_st(22, 22, 4'd3);
        set_st(23, 23, 4'd4); set_st(24, 24, 4'd5);
        set_st(30, 30, 4'd1); set_st(31, 31, 4'd2); set_st(32, 32, 4'd3);
        set_st(33, 45, 4'd4); set_st(46, 46, 4'd5);
        set_st(50, 50, 4'd1); set_st(51, 51, 4'd2); set_st(52, 52, 4'd3);
        set_st(53, 53, 4'd4); set_st(54, 54, 4'd5);
        set_st(60, 60, 4'd1); set_st(61, 61, 4'd2); set_st(62, 62, 4'd3);
        set_st(63, 63, 4'd4); set_st(64, 64, 4'd5);
        vecs[13].av = 1'b1; vecs[21].av = 1'b1; vecs[31].av = 1'b1;
        vecs[51].av = 1'b1; vecs[61].av = 1'b1;
        for (int i = 34; i <= 45; i++) vecs[i].dr = 1'b0;
        for (int i = 40; i <= 50; i++) vecs[i].ov = 1'b1;
        vecs[51].clr = 1'b1;
        for (int i = 62; i <= NROWS; i++) vecs[i].en = 1'b0;

        // Reset both instances for two cycles.
        reset = 1'b1;
        ifa.enable = 1'b1; ifa.adc_valid = 1'b0; ifa.dac_ready = 1'b1; ifa.status_clr = 1'b0;
        ifb.enable = 1'b0; ifb.adc_valid = 1'b0; ifb.dac_ready = 1'b0; ifb.status_clr = 1'b0;
        step();
        step();
        check_a("reset_a", vecs[0]);
        chk("reset_b state", int'(ifb.state), 0);
        chk("reset_b overrun", int'(ifb.overrun), 0);
        reset = 1'b0;

        // Nominal iterations, overrun, status clear and enable drop as one timed table.
        for (int i = 1; i <= NROWS; i++) begin
            ifa.enable     = vecs[i].en;
            ifa.adc_valid  = vecs[i].av;
            ifa.dac_ready  = vecs[i].dr;
            ifa.status_clr = vecs[i].clr;
            exp_q.push_back(vecs[i]);
            step();
            e = exp_q.pop_front();
            check_a($sformatf("row%0d", i), e);
        end

        // Reset while stalled in OUTPUT.
        ifa.enable = 1'b1; ifa.adc_valid = 1'b1; ifa.dac_ready = 1'b0; ifa.status_clr = 1'b0;
        n = 0;
        while (ifa.state != 4'd4 && n < 40) begin
            step();
            n++;
        end
        chk("reach_output state", int'(ifa.state), 4);
        step();
        step();
        chk("stall_output dac_valid", int'(ifa.dac_valid), 1);
        reset = 1'b1;
        step();
        chk("rst_in_output state", int'(ifa.state), 0);
        chk("rst_in_output dac_valid", int'(ifa.dac_valid), 0);
        chk("rst_in_output overrun", int'(ifa.overrun), 0);
        chk("rst_in_output fault", int'(ifa.fault), 0);
        step();
        chk("rst_hold state", int'(ifa.state), 0);
        reset = 1'b0; ifa.adc_valid = 1'b0; ifa.dac_ready = 1'b1;
        n = 0;
        while (ifa.adc_req != 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("first_adc_req clocks", n, 10);
        chk("first_adc_req state", int'(ifa.state), 1);

`ifdef PI_SEQ_TIMEOUT_EN
        // adc_valid never comes: 16 clocks in SAMPLE, then FAULT until cleared.
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("to_wait%0d state", i), int'(ifa.state), 1);
        end
        step();
        chk("timeout state", int'(ifa.state), 15);
        chk("timeout fault", int'(ifa.fault), 1);
        chk("timeout adc_req", int'(ifa.adc_req), 0);
        step();
        step();
        chk("fault_hold state", int'(ifa.state), 15);
        chk("fault_hold strobes", int'({ifa.dac_valid, ifa.u_prev_load, ifa.cycle_done}), 0);
        ifa.status_clr = 1'b1;
        step();
        ifa.status_clr = 1'b0;
        chk("fault_clr state", int'(ifa.state), 0);
        chk("fault_clr fault", int'(ifa.fault), 0);
`else
        // Without the timeout the ADC handshake waits indefinitely.
        for (int i = 0; i < 30; i++) step();
        chk("no_timeout state", int'(ifa.state), 1);
        chk("no_timeout fault", int'(ifa.fault), 0);
`endif
        ifa.enable = 1'b0;

        // Wide compute window on instance B.
        ifb.enable = 1'b1; ifb.adc_valid = 1'b1; ifb.dac_ready = 1'b1;
        n = 0;
        while (ifb.state != 4'd2 && n < 30) begin
            step();
            n++;
        end
        chk("b_reach_ce state", int'(ifb.state), 2);
        n = 1;
        step();
        while (ifb.state == 4'd2 && n < 20) begin
            n++;
            step();
        end
        chk("b_ce clocks", n, 4);
        chk("b_after_ce state", int'(ifb.state), 3);
        step();
        chk("b_cu clocks", int'(ifb.state), 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pi_loop_sequencer.md
Name: pi_loop_sequencer

Overview:
- Master sequencer for the digital PI loop. Generates the 4-bit state code broadcast to the datapath blocks (error, PI terms, control output).
- Paces loop iterations from a programmable sample-rate divider and handshakes with the ADC front end and the DAC back end.
- Issues the u_prev reload strobe and reports overrun and fault status.

Parameters:
- SAMPLE_DIV, 16'd1000, clocks per loop iteration; legal range 8..65535.
- ERR_CYCLES, 4'd1, clocks spent in COMPUTE_E; legal range 1..15.
- TIMEOUT_CYCLES, 16'd256, handshake wait limit in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  loop run enable.
- adc_valid  in  1  ADC sample ready; consumed in SAMPLE.
- dac_ready  in  1  DAC accepts the output word.
- status_clr  in  1  clears overrun, and fault when the optional feature is compiled in.
- state  out  4  current sequencer state code, to the datapath.
- adc_req  out  1  high while in SAMPLE.
- dac_valid  out  1  high while in OUTPUT.
- u_prev_load  out  1  one-cycle strobe; datapath latches u_out into u_prev.
- cycle_done  out  1  one-cycle strobe at iteration end.
- overrun  out  1  sticky: a sample tick arrived while busy.
- fault  out  1  sticky handshake timeout.

Behaviour:
- State encoding: IDLE=0, SAMPLE=1, COMPUTE_E=2, COMPUTE_U=3, OUTPUT=4, UPDATE=5, FAULT=15. Codes 6..14 are unused and return to IDLE on the next edge.
- state is a register. adc_req, dac_valid, u_prev_load and cycle_done are decoded only from the state register; there is no input-to-output combinational path.
- Reset (any state, any cycle): state=0, divider=0, ERR/timeout counters=0, overrun=0, fault=0. All outputs read 0 after the edge.
- Divider:
  - While enable=1, counts 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted for the cycle in which count==SAMPLE_DIV-1.
  - While enable=0, the divider is held at 0, so the first tick comes SAMPLE_DIV clocks after enable rises.
- Transitions:
  - IDLE -> SAMPLE on tick with enable=1.
  - SAMPLE: holds until adc_valid=1, then -> COMPUTE_E next edge.
  - COMPUTE_E: stays exactly ERR_CYCLES clocks, then -> COMPUTE_U.
  - COMPUTE_U: exactly 1 clock; the datapath registers u_out on this edge. Then -> OUTPUT.
  - OUTPUT: holds until dac_ready=1 (transfer = dac_valid & dac_ready), then -> UPDATE.
  - UPDATE: 1 clock with u_prev_load=1 and cycle_done=1, then -> IDLE.
- Minimum iteration latency with zero-wait handshakes: 4+ERR_CYCLES clocks, from the SAMPLE entry edge to the IDLE return edge.
- Overrun:
  - A tick is accepted only when state==IDLE.
  - A tick in any other state (including UPDATE and FAULT) is dropped and sets overrun.
  - If overrun set and status_clr occur in the same cycle, set wins.
- enable deasserted mid-iteration: the current iteration completes normally to IDLE. No new SAMPLE entry occurs while enable=0.
- Without the optional feature, status_clr clears overrun only, and only if no set occurs in that cycle.

Optional Feature:
- Macro: PI_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to SAMPLE or OUTPUT and increments each cycle the handshake is not met.
  - When it reaches TIMEOUT_CYCLES with the handshake still unmet -> FAULT, fault=1.
  - In FAULT: adc_req=0, dac_valid=0, no strobes. FAULT is held until status_clr=1, then -> IDLE next edge, fault=0, overrun=0.
  - Reset also exits FAULT.
- Undefined:
  - No wait counter; the handshakes wait indefinitely.
  - FAULT is unreachable, fault is tied 0, and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset: assert reset 2 cycles during OUTPUT with dac_ready=0 -> after the edge state=0, dac_valid=0, overrun=0, fault=0; first adc_req exactly SAMPLE_DIV clocks after reset release with enable=1.
- Nominal (SAMPLE_DIV=10, ERR_CYCLES=1): adc_valid 2 clocks after adc_req, dac_ready tied 1 -> state 0,1,1,1,2,3,4,5,0; exactly one u_prev_load and one cycle_done pulse per 10 clocks; overrun=0.
- Overrun (SAMPLE_DIV=10): hold dac_ready=0 for 12 clocks -> overrun=1 at the tick during OUTPUT; the iteration still completes; the next SAMPLE starts at the following tick; status_clr pulse -> overrun=0.
- Enable drop: deassert enable in COMPUTE_E -> COMPUTE_U, OUTPUT, UPDATE, IDLE occur; then no adc_req for 50 clocks.
- Timeout (PI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): adc_valid never asserted -> state=15, fault=1 after 16 clocks in SAMPLE; adc_req=0; status_clr -> state=0, fault=0 next edge.
- Wide ERR (ERR_CYCLES=4): state=2 for exactly 4 consecutive clocks; state=3 for exactly 1.
